// File: rtl/chameleon2_io_ps2iec_reader.sv
// -----------------------------------------------------------------------------
// chameleon2_io_ps2iec_reader
//
// Reads the shared 4-bit ps2iec input bus. The bus carries either the IEC
// lines or the PS/2 lines, depending on ps2iec_sel. The block alternates
// ps2iec_sel between the two groups and holds each group for S clocks,
// where S = max(SETTLE_CYCLES, 4). On the last clock of each group it
// captures the synchronized bus. Each bit passes through a two-capture
// agreement filter, so the outputs present stable line levels.
//
// Ports
//   clk                  system clock (sysclk, 100 MHz)
//   reset                synchronous, active-high reset
//   ps2iec[3:0]          raw multiplexed bus, asynchronous to clk
//   ps2iec_sel           mux select: 0 = IEC group, 1 = PS/2 group (registered)
//   iec_*_in             filtered IEC levels (atn, clk, dat, srq = bits 0..3)
//   ps2_*_in             filtered PS/2 levels (mouse clk/dat, keyboard clk/dat
//                        = bits 0..3)
//   iec_strobe           1-cycle pulse after an IEC capture
//   ps2_strobe           1-cycle pulse after a PS/2 capture
// -----------------------------------------------------------------------------
module chameleon2_io_ps2iec_reader #(
   parameter int SETTLE_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ps2iec,
   output logic       ps2iec_sel,
   output logic       iec_atn_in,
   output logic       iec_clk_in,
   output logic       iec_dat_in,
   output logic       iec_srq_in,
   output logic       ps2_mouse_clk_in,
   output logic       ps2_mouse_dat_in,
   output logic       ps2_keyboard_clk_in,
   output logic       ps2_keyboard_dat_in,
   output logic       iec_strobe,
   output logic       ps2_strobe
);

   // Settle times below 4 would let the 2-cycle synchronizer latency reach
   // back into the previous group, so they are clamped.
   localparam int         S_INT    = (SETTLE_CYCLES < 4) ? 4 : SETTLE_CYCLES;
   localparam logic [7:0] CNT_LAST = 8'(S_INT - 1);

   typedef enum logic {
      ST_IEC = 1'b0,
      ST_PS2 = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       sel_q, sel_d;
   logic [3:0] sync1_q, sync2_q;
   logic [3:0] iec_raw_q, iec_raw_d, iec_flt_q, iec_flt_d;
   logic [3:0] ps2_raw_q, ps2_raw_d, ps2_flt_q, ps2_flt_d;
   logic       iec_stb_q, iec_stb_d, ps2_stb_q, ps2_stb_d;

   // A bit follows the new sample only when the sample matches the previous
   // raw capture. Otherwise the bit keeps its filtered value.
   function automatic logic [3:0] agree_filter(input logic [3:0] smp,
                                               input logic [3:0] last_raw,
                                               input logic [3:0] flt);
      logic [3:0] eq;
      eq = ~(smp ^ last_raw);
      return (eq & smp) | (~eq & flt);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 4'b1111;
         sync2_q   <= 4'b1111;
         state_q   <= ST_IEC;
         cnt_q     <= 8'd0;
         sel_q     <= 1'b0;
         iec_raw_q <= 4'b1111;
         iec_flt_q <= 4'b1111;
         ps2_raw_q <= 4'b1111;
         ps2_flt_q <= 4'b1111;
         iec_stb_q <= 1'b0;
         ps2_stb_q <= 1'b0;
      end else begin
         sync1_q   <= ps2iec;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         iec_raw_q <= iec_raw_d;
         iec_flt_q <= iec_flt_d;
         ps2_raw_q <= ps2_raw_d;
         ps2_flt_q <= ps2_flt_d;
         iec_stb_q <= iec_stb_d;
         ps2_stb_q <= ps2_stb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 8'd1;
      iec_raw_d = iec_raw_q;
      iec_flt_d = iec_flt_q;
      ps2_raw_d = ps2_raw_q;
      ps2_flt_d = ps2_flt_q;
      iec_stb_d = 1'b0;
      ps2_stb_d = 1'b0;

      if (cnt_q == CNT_LAST) begin
         cnt_d = 8'd0;
         case (state_q)
            ST_IEC: begin
               iec_flt_d = agree_filter(sync2_q, iec_raw_q, iec_flt_q);
               iec_raw_d = sync2_q;
               iec_stb_d = 1'b1;
               state_d   = ST_PS2;
            end
            default: begin
               ps2_flt_d = agree_filter(sync2_q, ps2_raw_q, ps2_flt_q);
               ps2_raw_d = sync2_q;
               ps2_stb_d = 1'b1;
               state_d   = ST_IEC;
            end
         endcase
      end

      // Registering the next state keeps sel aligned with the state register.
      sel_d = (state_d == ST_PS2);
   end

   assign ps2iec_sel          = sel_q;
   assign iec_atn_in          = iec_flt_q[0];
   assign iec_clk_in          = iec_flt_q[1];
   assign iec_dat_in          = iec_flt_q[2];
   assign iec_srq_in          = iec_flt_q[3];
   assign ps2_mouse_clk_in    = ps2_flt_q[0];
   assign ps2_mouse_dat_in    = ps2_flt_q[1];
   assign ps2_keyboard_clk_in = ps2_flt_q[2];
   assign ps2_keyboard_dat_in = ps2_flt_q[3];
   assign iec_strobe          = iec_stb_q;
   assign ps2_strobe          = ps2_stb_q;

endmodule

// File: tb/tb_chameleon2_io_ps2iec_reader.sv
// -----------------------------------------------------------------------------
// tb_chameleon2_io_ps2iec_reader
//
// Drives two instances of the reader, one with SETTLE_CYCLES=10 and one with
// SETTLE_CYCLES=2 (clamped to 4). Each instance has its own pins, and the pins
// follow the group that instance is currently selecting. A cycle-indexed
// reference model predicts the select phase, the strobes and the filtered
// levels. The model works from the elapsed cycle count since reset and from a
// per-cycle history of pin values.
// -----------------------------------------------------------------------------
module tb_chameleon2_io_ps2iec_reader;

   localparam logic [3:0] F = 4'b1111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pin_a = F, pin_b = F;
   logic [1:0] sel, istb, pstb;
   logic [3:0] iec_a, iec_b, ps2_a, ps2_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state, one slot per instance.
   int         s_len [2] = '{10, 4};
   int         c     [2];
   logic [3:0] m_iec [2], m_ps2 [2], r_iec [2], r_ps2 [2];
   logic       m_is  [2], m_ps  [2];
   logic [3:0] hist0 [$];
   logic [3:0] hist1 [$];

   always #5 clk = ~clk;

   chameleon2_io_ps2iec_reader #(.SETTLE_CYCLES(10)) u_a (
      .clk(clk), .reset(reset), .ps2iec(pin_a), .ps2iec_sel(sel[0]),
      .iec_atn_in(iec_a[0]), .iec_clk_in(iec_a[1]), .iec_dat_in(iec_a[2]),
      .iec_srq_in(iec_a[3]),
      .ps2_mouse_clk_in(ps2_a[0]), .ps2_mouse_dat_in(ps2_a[1]),
      .ps2_keyboard_clk_in(ps2_a[2]), .ps2_keyboard_dat_in(ps2_a[3]),
      .iec_strobe(istb[0]), .ps2_strobe(pstb[0]));

   chameleon2_io_ps2iec_reader #(.SETTLE_CYCLES(2)) u_b (
      .clk(clk), .reset(reset), .ps2iec(pin_b), .ps2iec_sel(sel[1]),
      .iec_atn_in(iec_b[0]), .iec_clk_in(iec_b[1]), .iec_dat_in(iec_b[2]),
      .iec_srq_in(iec_b[3]),
      .ps2_mouse_clk_in(ps2_b[0]), .ps2_mouse_dat_in(ps2_b[1]),
      .ps2_keyboard_clk_in(ps2_b[2]), .ps2_keyboard_dat_in(ps2_b[3]),
      .iec_strobe(istb[1]), .ps2_strobe(pstb[1]));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int k);
      c[k]     = 0;
      m_iec[k] = F;
      m_ps2[k] = F;
      r_iec[k] = F;
      r_ps2[k] = F;
      m_is[k]  = 1'b0;
      m_ps[k]  = 1'b0;
      if (k == 0) hist0.delete();
      else        hist1.delete();
   endtask

   // One clock cycle: compare against the model, drive pins, advance the model.
   task automatic step(input logic [3:0] p_iec, input logic [3:0] p_ps2, input bit do_rst);
      logic [3:0] obs_iec, obs_ps2, pin, smp;
      logic       ph;
      int         pos;
      for (int k = 0; k < 2; k++) begin
         obs_iec = (k == 1) ? iec_b : iec_a;
         obs_ps2 = (k == 1) ? ps2_b : ps2_a;
         ph  = ((c[k] / s_len[k]) % 2) == 1;
         pos = c[k] % (2 * s_len[k]);
         chk($sformatf("u%0d.sel c%0d", k, cyc), {3'd0, sel[k]}, {3'd0, ph});
         chk($sformatf("u%0d.iec_strobe c%0d", k, cyc), {3'd0, istb[k]}, {3'd0, m_is[k]});
         chk($sformatf("u%0d.ps2_strobe c%0d", k, cyc), {3'd0, pstb[k]}, {3'd0, m_ps[k]});
         chk($sformatf("u%0d.iec c%0d", k, cyc), obs_iec, m_iec[k]);
         chk($sformatf("u%0d.ps2 c%0d", k, cyc), obs_ps2, m_ps2[k]);

         pin = ph ? p_ps2 : p_iec;
         if (k == 0) begin pin_a = pin; hist0.push_back(pin); end
         else        begin pin_b = pin; hist1.push_back(pin); end

         m_is[k] = 1'b0;
         m_ps[k] = 1'b0;
         if (do_rst) begin
            model_reset(k);
         end else begin
            if ((c[k] % s_len[k]) == s_len[k] - 1) begin
               // The captured value is the pin from two cycles earlier.
               smp = (k == 0) ? hist0[c[k] - 2] : hist1[c[k] - 2];
               for (int b = 0; b < 4; b++) begin
                  if (!ph) begin
                     if (smp[b] == r_iec[k][b]) m_iec[k][b] = smp[b];
                  end else begin
                     if (smp[b] == r_ps2[k][b]) m_ps2[k][b] = smp[b];
                  end
               end
               if (!ph) begin r_iec[k] = smp; m_is[k] = 1'b1; end
               else     begin r_ps2[k] = smp; m_ps[k] = 1'b1; end
            end
            if (pos < 0) c[k] = 0;
            c[k]++;
         end
      end
      reset = do_rst;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic [3:0] hold_i, hold_p, pi, pp;
      bit         noisy, rr;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_reset(0);
      model_reset(1);

      // Idle bus: plain select cadence and strobe timing.
      repeat (40) step(F, F, 1'b0);

      // PS/2 group pattern only.
      repeat (60) step(F, 4'b0101, 1'b0);
      repeat (40) step(F, F, 1'b0);

      // ATN held low for two rounds, then released.
      repeat (40) step(4'b1110, F, 1'b0);
      repeat (60) step(F, F, 1'b0);

      // DAT low during a single IEC capture window (positions 7..9).
      for (int i = 0; i < 60; i++) begin
         if ((c[0] % 20) >= 7 && (c[0] % 20) <= 9 && i >= 20 && i < 40)
            step(4'b1011, F, 1'b0);
         else
            step(F, F, 1'b0);
      end

      // Put PS/2 outputs at 0, then reset on the last PS2 cycle with new data present.
      repeat (60) step(F, 4'b0000, 1'b0);
      while ((c[0] % 20) != 19) step(F, 4'b1010, 1'b0);
      step(F, 4'b1010, 1'b1);
      repeat (40) step(F, F, 1'b0);

      // Randomized traffic: held levels per 20-cycle block, occasional noise and resets.
      hold_i = F;
      hold_p = F;
      noisy  = 1'b0;
      for (int i = 0; i < 2400; i++) begin
         if ((i % 20) == 0) begin
            hold_i = 4'($urandom);
            hold_p = 4'($urandom);
            noisy  = ($urandom_range(0, 3) == 0);
         end
         pi = noisy ? 4'($urandom) : hold_i;
         pp = noisy ? 4'($urandom) : hold_p;
         rr = ($urandom_range(0, 299) == 0);
         step(pi, pp, rr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
